// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stage: phase encodings and the
// elaboration-time quarter-wave cosine table generator.
package fft_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    BFLY = 2'd2
  } phase_e;

  localparam real PI = 3.14159265358979323846;

  // C[j] = round(2^frac_w * cos(pi*j/2^log2h)), half away from zero.
  // Evaluated only with constant arguments; cosine via Taylor series so the
  // table does not depend on tool support for math system functions.
  // Entries are never negative because j <= H/2.
  function automatic int qcos_entry(input int j, input int log2h, input int frac_w);
    real x;
    real term;
    real sum;
    real scale;
    x     = PI * $itor(j) / $itor(1 << log2h);
    sum   = 1.0;
    term  = 1.0;
    for (int n = 1; n <= 24; n++) begin
      term = -term * x * x / $itor((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    scale = 1.0;
    for (int b = 0; b < frac_w; b++) begin
      scale = scale * 2.0;
    end
    if (sum < 0.0) begin
      sum = 0.0;
    end
    return $rtoi(sum * scale + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine lookup: H/2+1 unsigned entries, combinational read.
module twiddle_qrom
  import fft_pkg::*;
#(
  parameter int LOG2H  = 3,
  parameter int FRAC_W = 8
) (
  input  logic [LOG2H-1:0] addr,
  output logic [FRAC_W:0]  data
);

  localparam int HALF = (1 << LOG2H) / 2;

  logic [FRAC_W:0] rom [0:HALF];

  for (genvar g = 0; g <= HALF; g++) begin : g_rom
    localparam int CV = qcos_entry(g, LOG2H, FRAC_W);
    assign rom[g] = CV[FRAC_W:0];
  end

  // Table read; addresses past H/2 never occur but read as zero.
  always_comb begin
    data = '0;
    if (int'(addr) <= HALF) begin
      data = rom[addr];
    end
  end

endmodule

// File: rtl/sdf_twiddle_gen.sv
// Phase controller and twiddle generator for one radix-2 SDF FFT stage.
// Outputs are registered from next-state values so they always describe the
// sample currently presented.
module sdf_twiddle_gen
  import fft_pkg::*;
#(
  parameter int LOG2H  = 3,
  parameter int DATA_W = 24,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     flush,
  input  logic                     inv,
  output logic [1:0]               state,
  output logic signed [DATA_W-1:0] w_r,
  output logic signed [DATA_W-1:0] w_i,
  output logic                     blk_last
);

  localparam int CW = LOG2H + 1;
  localparam int H  = 1 << LOG2H;
  localparam logic [CW-1:0]    H_C    = CW'(H);
  localparam logic [CW-1:0]    P_LAST = CW'(2 * H - 1);
  localparam logic [LOG2H-1:0] HALF_C = LOG2H'(H / 2);
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] p_q, p_d;
  logic          inv_q, inv_d;
  logic [1:0]    state_q, state_d;
  logic signed [DATA_W-1:0] w_r_q, w_r_d;
  logic signed [DATA_W-1:0] w_i_q, w_i_d;
  logic          blk_last_q, blk_last_d;

  logic [LOG2H-1:0] k_d, cos_addr, sin_addr;
  logic             cos_neg;
  logic [FRAC_W:0]  cos_mag, sin_mag;
  logic signed [DATA_W-1:0] cos_ext, sin_ext;

  // Counter and mode update; flush overrides a simultaneous accepted sample.
  always_comb begin
    fill_d = fill_q;
    p_d    = p_q;
    inv_d  = inv_q;
    if (flush) begin
      fill_d = '0;
      p_d    = '0;
      inv_d  = inv;
    end else if (in_valid) begin
      if (fill_q < H_C) begin
        fill_d = fill_q + 1'b1;
        if (fill_q == H_C - 1'b1) begin
          inv_d = inv;
        end
      end else begin
        p_d = p_q + 1'b1;
        if (p_q == P_LAST) begin
          inv_d = inv;
        end
      end
    end
  end

  // Fold k = p-H onto the quarter-wave table for the next sample.
  always_comb begin
    k_d = p_d[LOG2H-1:0];
    if (k_d <= HALF_C) begin
      cos_addr = k_d;
      sin_addr = HALF_C - k_d;
      cos_neg  = 1'b0;
    end else begin
      cos_addr = '0 - k_d;
      sin_addr = k_d - HALF_C;
      cos_neg  = 1'b1;
    end
  end

  twiddle_qrom #(.LOG2H(LOG2H), .FRAC_W(FRAC_W)) u_cos_rom (
    .addr (cos_addr),
    .data (cos_mag)
  );

  twiddle_qrom #(.LOG2H(LOG2H), .FRAC_W(FRAC_W)) u_sin_rom (
    .addr (sin_addr),
    .data (sin_mag)
  );

  assign cos_ext = DATA_W'(cos_mag);
  assign sin_ext = DATA_W'(sin_mag);

  // Phase, twiddle and block marker for the next presented sample.
  always_comb begin
    state_d    = FILL;
    w_r_d      = ONE;
    w_i_d      = '0;
    blk_last_d = 1'b0;
    if (fill_d < H_C) begin
      state_d = FILL;
    end else if (!p_d[LOG2H]) begin
      state_d = LOAD;
    end else begin
      state_d    = BFLY;
      w_r_d      = cos_neg ? -cos_ext : cos_ext;
      w_i_d      = inv_d ? sin_ext : -sin_ext;
      blk_last_d = (p_d == P_LAST);
    end
  end

  // State and output registers; frozen unless a sample is accepted or flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q     <= '0;
      p_q        <= '0;
      inv_q      <= 1'b0;
      state_q    <= FILL;
      w_r_q      <= ONE;
      w_i_q      <= '0;
      blk_last_q <= 1'b0;
    end else if (flush || in_valid) begin
      fill_q     <= fill_d;
      p_q        <= p_d;
      inv_q      <= inv_d;
      state_q    <= state_d;
      w_r_q      <= w_r_d;
      w_i_q      <= w_i_d;
      blk_last_q <= blk_last_d;
    end
  end

  assign state    = state_q;
  assign w_r      = w_r_q;
  assign w_i      = w_i_q;
  assign blk_last = blk_last_q;

endmodule

// File: doc/sdf_twiddle_gen.md
# sdf_twiddle_gen

Parametrised twiddle-factor generator and phase controller for one radix-2 single-path delay-feedback (SDF) FFT stage with butterfly span H = 2^LOG2H. It counts accepted input samples, reports the stage phase (fill / load / butterfly), and supplies the matching twiddle W_2H^k in signed fixed point. A quarter-wave cosine table reduces storage. It also adds input-gated counting, an inverse-FFT (conjugate) mode, a synchronous flush and a block-end marker.

## Interface
- LOG2H, 3, log2 of butterfly span H (delay-line length); legal range 1..10
- DATA_W, 24, twiddle output width, two's complement
- FRAC_W, 8, fractional bits; 1.0 = 2^FRAC_W; requires FRAC_W+2 ≤ DATA_W
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  one stage input sample accepted this cycle
- flush  in  1  synchronous restart of the stage sequence
- inv  in  1  1 = inverse transform (conjugate twiddles)
- state  out  2  phase of the sample presented this cycle: 0 FILL, 1 LOAD, 2 BFLY
- w_r  out  DATA_W  twiddle real part for the sample presented this cycle
- w_i  out  DATA_W  twiddle imaginary part for the sample presented this cycle
- blk_last  out  1  high while the presented sample is the last BFLY sample of a block

## Operation
- Fill counter (LOG2H+1 bits, saturating): counts the first H accepted samples. Phase is FILL while fewer than H samples have been accepted.
- Phase counter p (LOG2H+1 bits, wraps 2H-1 → 0): starts at 0 after fill and advances only on accepted samples.
  - p < H: LOAD, twiddle = 1.0.
  - p ≥ H: BFLY, k = p−H.
- FILL twiddle = 1.0. blk_last = 1 iff BFLY and p = 2H−1.
- BFLY twiddle: w_r = cos(πk/H), w_i = −sin(πk/H); with inv_q = 1, w_i = +sin(πk/H).
- Quarter-wave table C[j] = round(2^FRAC_W·cos(πj/H)), j = 0..H/2, rounded half away from zero.
  - k ≤ H/2: cos = C[k], sin = C[H/2−k].
  - k > H/2, m = k−H/2: cos = −C[H/2−m], sin = C[m].
- Table values are sign-extended to DATA_W. Negation is exact two's complement; no saturation is needed.
- inv_q register:
  - Loaded from inv on reset (to 0), on flush, and on the accepted sample that ends FILL or ends a block (p = 2H−1).
  - Mode therefore never changes inside a block.
- Flush: clears the fill counter, p and inv_q (then loads inv), and returns the outputs to their reset values. flush wins over a simultaneous in_valid; that sample is not counted.
- in_valid low: all state frozen and outputs held.

## Timing
- All outputs are registered. On a clock edge with in_valid=1, the outputs load the values for the next sample index. Outputs always describe the sample currently presented, with zero added latency.
- Reset values: state=0, w_r=2^FRAC_W, w_i=0, blk_last=0, counters 0, inv_q=0.
- rst asserted mid-operation clears everything immediately (asynchronously). The first sample after deassertion is FILL sample 0.
- Continuous in_valid sequence: H cycles FILL, then repeating H LOAD, H BFLY.
- p wrap-around from 2H−1 to 0 is seamless; there is no bubble cycle.

## Structure
- Shared package fft_pkg holds:
  - the state encodings FILL=2'd0, LOAD=2'd1, BFLY=2'd2;
  - a constant function for the quarter-wave table entries, evaluated at elaboration.
- One sub-module, twiddle_qrom:
  - combinational lookup of C[] with H/2+1 entries, parameterised by LOG2H and FRAC_W;
  - the parent performs the symmetry mapping, negation and output registering.

## Test plan
- Reset with LOG2H=3, FRAC_W=8, DATA_W=24 → state=0, w_r=256, w_i=0, blk_last=0.
- 32 cycles of continuous in_valid:
  - states: 8×0, 8×1 (256,0), then 8×2.
  - BFLY (w_r,w_i) pairs: (256,0), (237,−98), (181,−181), (98,−237), (0,−256), (−98,−237), (−181,−181), (−237,−98).
  - blk_last high on the 24th presented sample only; sample 25 is LOAD.
- Random in_valid gaps → state, w_r, w_i frozen across gaps; the sequence is identical to the gapless sequence when compared per accepted sample.
- Toggle inv=1 mid-BFLY → current block unchanged; next block BFLY k=1 gives (237,+98) and k=4 gives (0,+256).
- flush asserted together with in_valid at BFLY k=3 → next cycle state=0, w_r=256, w_i=0; a full 8-sample FILL follows. An asynchronous rst pulse mid-LOAD gives the same result.
- Parameter sweep LOG2H=1, 5, 10 with random in_valid → cycle-exact match against a real-arithmetic reference model, including the C[] rounding rule and the extremes k=0 and k=H/2.
